// File: rtl/seg_value_formatter_pkg.sv
// Shared display-path definitions: segment glyphs, segment bit positions,
// formatter FSM encoding and a small helper for decimal range limits.
package seg_pkg;

    // Segment bit positions inside a 7-bit glyph, a..g, active-high
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } fmt_state_e;

    // 10^n at 64 bits; wide enough for any realistic value width plus one
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_value_formatter_if.sv
// Value handshake and pixel bus between the upstream feeder, the formatter
// and the glyph renderer.
// Handshake: a value transfers on a rising clk edge where val_valid and
// val_ready are both high; val_ready is high only while the formatter is
// idle, and the upstream holds val_in stable until that transfer edge.
interface seg_value_formatter_if
    import seg_pkg::*;
#(
    parameter int VAL_W = 14
);
    logic [VAL_W-1:0] val_in;
    logic             val_valid;
    logic             val_ready;
    logic [8:0]       x;
    logic [8:0]       digit_x;
    logic [6:0]       seg_data;
    fmt_state_e       dbg_state;

    modport master (
        output val_in, val_valid, x,
        input  val_ready, digit_x, seg_data, dbg_state
    );

    modport slave (
        input  val_in, val_valid, x,
        output val_ready, digit_x, seg_data, dbg_state
    );
endinterface

// File: rtl/seg_value_formatter_bcd_to_seg.sv
// Combinational BCD nibble to seven-segment glyph decoder; codes 10..15
// decode to a blank cell.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    // Nibble lookup
    always_comb begin
        seg_o = SEG_BLANK;
        case (nib_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg_value_formatter.sv
// Binary value to seven-segment formatter: sequential double-dabble BCD
// conversion, leading-zero blanking / overflow dashes, atomic display
// register update, and a registered per-pixel digit-cell lookup.
module seg_value_formatter
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int VAL_W       = 14,
    parameter int DIGIT_PITCH = 80,
    parameter int BLANK_LZ    = 1
) (
    input  logic clk,
    input  logic rst,
    seg_value_formatter_if.slave bus
);
    localparam int          BCD_W     = 4 * DIGITS;
    localparam int          CNT_W     = $clog2(VAL_W + 1);
    localparam int          IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

    fmt_state_e         state_q, state_d;
    logic [VAL_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [6:0]         disp_q [DIGITS];
    logic [6:0]         disp_d [DIGITS];
    logic [6:0]         disp_new [DIGITS];
    logic [6:0]         glyph [DIGITS];
    logic [3:0]         digit_nib [DIGITS];
    logic [8:0]         digit_x_q, digit_x_d;
    logic [6:0]         seg_q, seg_d;
    logic [8:0]         idx;
    logic [8:0]         cell_start;
    logic               seen_nz;

    // Digit 0 is the leftmost / most significant nibble of the accumulator
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign digit_nib[g] = bcd_q[4*(DIGITS-1-g) +: 4];
        bcd_to_seg u_dec (
            .nib_i (digit_nib[g]),
            .seg_o (glyph[g])
        );
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // Display image for the finished conversion: dashes, blanking or glyphs
    always_comb begin
        seen_nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            disp_new[i] = glyph[i];
            if (ovf_q) begin
                disp_new[i] = SEG_DASH;
            end else if ((BLANK_LZ != 0) && !seen_nz && (i != DIGITS - 1)
                         && (digit_nib[i] == 4'd0)) begin
                disp_new[i] = SEG_BLANK;
            end else begin
                seen_nz = 1'b1;
            end
        end
    end

    // FSM next state and datapath: accept, shift VAL_W times, latch
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.val_valid) begin
                    shift_d = bus.val_in;
                    bcd_d   = '0;
                    ovf_d   = ({{(64-VAL_W){1'b0}}, bus.val_in} >= OVF_LIMIT);
                    cnt_d   = CNT_W'(VAL_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                disp_d  = disp_new;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Conversion and display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                disp_q[i] <= (i == DIGITS - 1) ? SEG_0 : SEG_BLANK;
            end
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
        end
    end

    // Pixel path: cell index by constant division, offset within the cell
    always_comb begin
        idx        = bus.x / 9'(DIGIT_PITCH);
        cell_start = 9'(idx * DIGIT_PITCH);
        digit_x_d  = bus.x - cell_start;
        seg_d      = SEG_BLANK;
        if (idx < 9'(DIGITS)) begin
            seg_d = disp_q[idx[IDX_W-1:0]];
        end
    end

    // Pixel output registers, one cycle behind x
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_x_q <= '0;
            seg_q     <= SEG_BLANK;
        end else begin
            digit_x_q <= digit_x_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.val_ready = (state_q == ST_IDLE);
    assign bus.digit_x   = digit_x_q;
    assign bus.seg_data  = seg_q;
    assign bus.dbg_state = state_q;

endmodule
